// File: rtl/pe_array_controller_pkg.sv
// Shared types and default geometry for the PE-array controller and the PE grid.
// The state encoding is common to both.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FILT,
    LOAD_IFMAP,
    CONV,
    DONE
  } ctrl_state_t;

  localparam int unsigned DEF_NUM_ROWS    = 3;
  localparam int unsigned DEF_NUM_DIAGS   = 5;
  localparam int unsigned DEF_CONV_CYCLES = 3;
  localparam int unsigned DEF_MAX_PASSES  = 16;

  // Index width for a counter over n items; never zero so single-item counters still elaborate.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_array_controller_if.sv
// PE control bus: command inputs plus the per-row / per-diagonal strobes into the PE grid.
// Signal prefixes are from the controller's point of view.
interface pe_array_controller_if #(
  parameter int unsigned NUM_ROWS  = 3,
  parameter int unsigned NUM_DIAGS = 5,
  parameter int unsigned PASS_W    = 5
);
  logic                 i_start;
  logic                 i_reuse_filter;
  logic [PASS_W-1:0]    i_num_passes;
  logic                 i_stall;
  logic                 i_abort;
  logic [NUM_ROWS-1:0]  o_read_new_filter_val;
  logic [NUM_DIAGS-1:0] o_read_new_ifmap_val;
  logic [NUM_DIAGS-1:0] o_start_conv;
  logic                 o_busy;
  logic                 o_done;

  // Command side issues runs and observes the strobes.
  modport master (
    output i_start, i_reuse_filter, i_num_passes, i_stall, i_abort,
    input  o_read_new_filter_val, o_read_new_ifmap_val, o_start_conv, o_busy, o_done
  );

  // Controller side.
  modport slave (
    input  i_start, i_reuse_filter, i_num_passes, i_stall, i_abort,
    output o_read_new_filter_val, o_read_new_ifmap_val, o_start_conv, o_busy, o_done
  );
endinterface

// File: rtl/pe_array_controller_onehot_strobe_dec.sv
// Index + enable to one-hot strobe vector; out-of-range index yields all zeros.
module onehot_strobe_dec #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_vec
);
  assign o_vec = i_en ? (WIDTH'(1) << i_idx) : '0;
endmodule

// File: rtl/pe_array_controller.sv
// Sequencer for the PE-array control fabric: filter load, per-pass ifmap load and conv start,
// with stall, abort and filter reuse. All outputs are registered.
module pe_array_controller
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS,
  parameter int unsigned NUM_DIAGS   = DEF_NUM_DIAGS,
  parameter int unsigned CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int unsigned MAX_PASSES  = DEF_MAX_PASSES
) (
  input logic                  clk,
  input logic                  rst_n,
  pe_array_controller_if.slave bus
);
  localparam int unsigned PASS_W = $clog2(MAX_PASSES + 1);
  localparam int unsigned ROW_W  = idx_w(NUM_ROWS);
  localparam int unsigned DIAG_W = idx_w(NUM_DIAGS);
  localparam int unsigned CONV_W = idx_w(CONV_CYCLES);

  ctrl_state_t          r_state, w_state_d;
  logic [ROW_W-1:0]     r_row, w_row_d;
  logic [DIAG_W-1:0]    r_diag, w_diag_d;
  logic [CONV_W-1:0]    r_conv, w_conv_d;
  logic [PASS_W-1:0]    r_pass, w_pass_d;
  logic [PASS_W-1:0]    r_npass, w_npass_d;
  logic [PASS_W-1:0]    w_pass_inc;
  logic                 w_emit;
  logic [NUM_ROWS-1:0]  w_filt_vec, r_filt;
  logic [NUM_DIAGS-1:0] w_ifmap_vec, r_ifmap, r_start_conv;
  logic                 r_busy, r_done;

  assign w_pass_inc = r_pass + PASS_W'(1);
  // A stalled or aborting cycle emits nothing; the held state re-issues its strobe later.
  assign w_emit     = !bus.i_stall && !bus.i_abort;

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_diag_d  = r_diag;
    w_conv_d  = r_conv;
    w_pass_d  = r_pass;
    w_npass_d = r_npass;
    if (bus.i_abort) begin
      w_state_d = IDLE;
      w_row_d   = '0;
      w_diag_d  = '0;
      w_conv_d  = '0;
      w_pass_d  = '0;
      w_npass_d = '0;
    end else if (!bus.i_stall) begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            w_npass_d = (bus.i_num_passes == '0) ? PASS_W'(1) : bus.i_num_passes;
            w_state_d = bus.i_reuse_filter ? LOAD_IFMAP : LOAD_FILT;
          end
        end
        LOAD_FILT: begin
          if (r_row == ROW_W'(NUM_ROWS - 1)) begin
            w_row_d   = '0;
            w_state_d = LOAD_IFMAP;
          end else begin
            w_row_d = r_row + ROW_W'(1);
          end
        end
        LOAD_IFMAP: begin
          if (r_diag == DIAG_W'(NUM_DIAGS - 1)) begin
            w_diag_d  = '0;
            w_state_d = CONV;
          end else begin
            w_diag_d = r_diag + DIAG_W'(1);
          end
        end
        CONV: begin
          if (r_conv == CONV_W'(CONV_CYCLES - 1)) begin
            w_conv_d = '0;
            if (w_pass_inc == r_npass) begin
              w_pass_d  = '0;
              w_state_d = DONE;
            end else begin
              w_pass_d  = w_pass_inc;
              w_state_d = LOAD_IFMAP;
            end
          end else begin
            w_conv_d = r_conv + CONV_W'(1);
          end
        end
        DONE:    w_state_d = IDLE;
        default: w_state_d = IDLE;
      endcase
    end
  end

  onehot_strobe_dec #(
    .WIDTH (NUM_ROWS),
    .IDX_W (ROW_W)
  ) u_filt_dec (
    .i_idx (r_row),
    .i_en  (w_emit && (r_state == LOAD_FILT)),
    .o_vec (w_filt_vec)
  );

  onehot_strobe_dec #(
    .WIDTH (NUM_DIAGS),
    .IDX_W (DIAG_W)
  ) u_ifmap_dec (
    .i_idx (r_diag),
    .i_en  (w_emit && (r_state == LOAD_IFMAP)),
    .o_vec (w_ifmap_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_diag       <= '0;
      r_conv       <= '0;
      r_pass       <= '0;
      r_npass      <= '0;
      r_filt       <= '0;
      r_ifmap      <= '0;
      r_start_conv <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_row        <= w_row_d;
      r_diag       <= w_diag_d;
      r_conv       <= w_conv_d;
      r_pass       <= w_pass_d;
      r_npass      <= w_npass_d;
      r_filt       <= w_filt_vec;
      r_ifmap      <= w_ifmap_vec;
      r_start_conv <= {NUM_DIAGS{w_emit && (r_state == CONV) && (r_conv == '0)}};
      r_busy       <= (w_state_d != IDLE);
      r_done       <= w_emit && (r_state == DONE);
    end
  end

  assign bus.o_read_new_filter_val = r_filt;
  assign bus.o_read_new_ifmap_val  = r_ifmap;
  assign bus.o_start_conv          = r_start_conv;
  assign bus.o_busy                = r_busy;
  assign bus.o_done                = r_done;

endmodule
